// File: rtl/bwt_pkg.sv
// ---------------------------------------------------------------------------
// bwt_pkg
// Shared constants and types for the BWT datapath (forward sort/merge and
// the inverse decoder).
//   BLOCK_LEN   : symbols per block (power of two, >= 2)
//   ELEMENT_LEN : bits per symbol
//   IDX_W       : width of a row index inside a block
//   sym_t       : one symbol
//   idx_t       : one row index
//   ibwt_state_t: inverse decoder phases LOAD -> RANK -> WALK -> EMIT
// ---------------------------------------------------------------------------
package bwt_pkg;

    localparam int BLOCK_LEN   = 8;
    localparam int ELEMENT_LEN = 8;
    localparam int IDX_W       = $clog2(BLOCK_LEN);

    typedef logic [ELEMENT_LEN-1:0] sym_t;
    typedef logic [IDX_W-1:0]       idx_t;

    // Index of the final row; used as the terminal count of every phase.
    localparam idx_t LAST_IDX = idx_t'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RANK = 2'd1,
        WALK = 2'd2,
        EMIT = 2'd3
    } ibwt_state_t;

endpackage

// File: rtl/lf_rank.sv
// ---------------------------------------------------------------------------
// lf_rank
// Combinational LF-mapping for one row of the last column L:
//   LF[i] = #{j : L[j] < L[i]} + #{j < i : L[j] == L[i]}
// Ties between equal symbols are broken by row order, which is what makes
// blocks of identical symbols decode correctly.
// Ports:
//   i_l   : the full L column, row 0 at index 0
//   i_row : row i being ranked
//   o_lf  : LF[i]; at most BLOCK_LEN-1, so it always fits in IDX_W bits
// ---------------------------------------------------------------------------
module lf_rank
    import bwt_pkg::*;
(
    input  logic [ELEMENT_LEN-1:0] i_l [BLOCK_LEN],
    input  logic [IDX_W-1:0]       i_row,
    output logic [IDX_W-1:0]       o_lf
);

    logic [ELEMENT_LEN-1:0] w_key;
    logic [BLOCK_LEN-1:0]   w_hit;
    logic [IDX_W-1:0]       w_sum;

    assign w_key = i_l[i_row];

    // One comparator per row: counts strictly smaller symbols, plus equal
    // symbols that sit in an earlier row.  Row i itself never hits.
    for (genvar gi = 0; gi < BLOCK_LEN; gi++) begin : g_cmp
        assign w_hit[gi] = (i_l[gi] < w_key) ||
                           ((i_l[gi] == w_key) && (IDX_W'(gi) < i_row));
    end

    // Popcount; row i never counts itself, so the total stays below BLOCK_LEN.
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < BLOCK_LEN; j++) begin
            w_sum = w_sum + IDX_W'(w_hit[j]);
        end
    end

    assign o_lf = w_sum;

endmodule

// File: rtl/inverse_bwt.sv
// ---------------------------------------------------------------------------
// inverse_bwt
// Inverse Burrows-Wheeler decoder for one fixed-length block.  Loads the last
// column L plus the primary index, ranks every row into the LF table, walks
// LF backwards from the primary row to rebuild the block, then streams the
// block out in forward order.
// Ports:
//   clk, rst     : clock (rising edge) and asynchronous active-low reset
//   in_valid     : L symbol valid
//   in_ready     : decoder is in LOAD and can take a symbol
//   in_data      : L symbol, row 0 first
//   primary_idx  : row holding the original string, taken with the first beat
//   out_valid    : decoded symbol valid
//   out_ready    : downstream accepts the symbol
//   out_data     : decoded symbol, S[0] first
//   out_last     : marks S[BLOCK_LEN-1]
//   busy         : high unless idle in LOAD with nothing loaded
// ---------------------------------------------------------------------------
module inverse_bwt
    import bwt_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ELEMENT_LEN-1:0] in_data,
    input  logic [IDX_W-1:0]       primary_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ELEMENT_LEN-1:0] out_data,
    output logic                   out_last,
    output logic                   busy
);

    ibwt_state_t r_state;
    idx_t        r_cnt;
    idx_t        r_p;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_out_last;
    sym_t        r_out_data;

    // Block storage; contents are don't-care after reset.
    sym_t r_l  [BLOCK_LEN];
    idx_t r_lf [BLOCK_LEN];
    sym_t r_s  [BLOCK_LEN];

    logic w_accept;
    idx_t w_cnt_inc;
    idx_t w_lf;

    assign w_accept  = (r_state == LOAD) && in_valid && r_in_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    lf_rank u_lf_rank (
        .i_l   (r_l),
        .i_row (r_cnt),
        .o_lf  (w_lf)
    );

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_p         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    // in_ready rises on the first clock after reset release.
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (r_cnt == '0) begin
                            r_p <= primary_idx;
                        end
                        if (r_cnt == LAST_IDX) begin
                            r_state    <= RANK;
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                RANK: begin
                    if (r_cnt == LAST_IDX) begin
                        r_state <= WALK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                WALK: begin
                    r_p <= r_lf[r_p];
                    if (r_cnt == LAST_IDX) begin
                        // The final step produces S[0]; forward it straight to
                        // the output register since r_s is written this same edge.
                        r_state     <= EMIT;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_l[r_p];
                        r_out_last  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (r_cnt == LAST_IDX) begin
                            r_state     <= LOAD;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            r_out_data <= r_s[w_cnt_inc];
                            r_out_last <= (w_cnt_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= LOAD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Array writes, enabled from registered state.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_l[r_cnt] <= in_data;
        end
        if (r_state == RANK) begin
            r_lf[r_cnt] <= w_lf;
        end
        // The walk recovers the block back to front.
        if (r_state == WALK) begin
            r_s[LAST_IDX - r_cnt] <= r_l[r_p];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = !((r_state == LOAD) && (r_cnt == '0));

endmodule

// File: tb/tb_inverse_bwt.sv
// ---------------------------------------------------------------------------
// tb_inverse_bwt
// Directed bench for inverse_bwt: known L columns with hand-derived decodes,
// output back-pressure, reset during WALK and back-to-back blocks with gaps.
// ---------------------------------------------------------------------------
module tb_inverse_bwt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] primary_idx = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    inverse_bwt dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .primary_idx (primary_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Feeds one block; called and returning on a falling edge.  t_acc is the
    // cycle count seen just before the final accepting edge.
    task automatic send(input logic [7:0] blk [8], input logic [2:0] p,
                        input bit gaps, output int t_acc);
        int t;
        t_acc = -1;
        for (int i = 0; i < 8; i++) begin
            if (gaps && (i % 3 == 1)) begin
                in_valid = 1'b0;
                repeat (2) @(negedge clk);
            end
            in_valid    = 1'b1;
            in_data     = blk[i];
            // A wrong index on non-first beats must be ignored.
            primary_idx = (i == 0) ? p : 3'(p + 3'(i));
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            t_acc = cyc;
            $display("in[%0d] = %02h (primary %0d)", i, blk[i], primary_idx);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Collects one decoded block, optionally with back-pressure.
    task automatic recv(input logic [7:0] exp [8], input bit stall, input int t_acc);
        int          idx     = 0;
        int          waited  = 0;
        int          pat     = 0;
        bit          seen    = 1'b0;
        bit          held    = 1'b0;
        logic [7:0]  held_d  = '0;
        logic        held_l  = 1'b0;
        logic [15:0] pat_bits = 16'b1001_0110_0100_1101;
        while (idx < 8 && waited < 300) begin
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("first_valid_latency", 32'(cyc - t_acc), 32'd17);
                end
                chk("in_ready_during_emit", {31'd0, in_ready}, 32'd0);
                chk("busy_during_emit", {31'd0, busy}, 32'd1);
                if (held) begin
                    chk("stall_hold_data", {24'd0, out_data}, {24'd0, held_d});
                    chk("stall_hold_last", {31'd0, out_last}, {31'd0, held_l});
                end
                out_ready = stall ? pat_bits[pat % 16] : 1'b1;
                pat++;
                if (out_ready) begin
                    $display("out[%0d] = %02h last=%0d", idx, out_data, out_last);
                    chk("out_data", {24'd0, out_data}, {24'd0, exp[idx]});
                    chk("out_last", {31'd0, out_last}, (idx == 7) ? 32'd1 : 32'd0);
                    idx++;
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    held_d = out_data;
                    held_l = out_last;
                end
            end
            @(negedge clk);
            waited++;
        end
        chk("recv_count", 32'(idx), 32'd8);
        chk("in_ready_after_last", {31'd0, in_ready}, 32'd1);
        chk("out_valid_after_last", {31'd0, out_valid}, 32'd0);
        chk("busy_after_last", {31'd0, busy}, 32'd0);
        out_ready = 1'b1;
    endtask

    logic [7:0] v1   [8];
    logic [7:0] v1_e [8];
    logic [7:0] v2   [8];
    logic [7:0] v2_e [8];
    logic [7:0] v3   [8];

    initial begin
        int ta;
        v1   = '{8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        v1_e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        v2   = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h01};
        v2_e = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        v3   = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41};

        // Power-on reset.
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);

        // Block with ascending decode.
        send(v1, 3'd0, 1'b0, ta);
        chk("busy_in_rank", {31'd0, busy}, 32'd1);
        chk("in_ready_in_rank", {31'd0, in_ready}, 32'd0);
        recv(v1_e, 1'b0, ta);

        // Block with descending decode, primary at the last row.
        send(v2, 3'd7, 1'b0, ta);
        recv(v2_e, 1'b0, ta);

        // All-equal symbols: every row ties.
        send(v3, 3'd5, 1'b0, ta);
        recv(v3, 1'b0, ta);

        // Back-pressure on the output with in_valid held high throughout.
        send(v2, 3'd7, 1'b0, ta);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        recv(v2_e, 1'b1, ta);
        in_valid = 1'b0;

        // Reset in the middle of WALK discards the block.
        send(v3, 3'd5, 1'b0, ta);
        repeat (12) @(negedge clk);
        chk("busy_in_walk", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_last",  {31'd0, out_last},  32'd0);
        chk("midrst_out_data",  {24'd0, out_data},  32'd0);
        chk("midrst_busy",      {31'd0, busy},      32'd0);
        @(negedge clk);
        chk("midrst_hold_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready_release", {31'd0, in_ready}, 32'd1);
        chk("midrst_no_output", {31'd0, out_valid}, 32'd0);
        send(v1, 3'd0, 1'b0, ta);
        recv(v1_e, 1'b0, ta);

        // Back-to-back blocks with input gaps.
        send(v1, 3'd0, 1'b1, ta);
        recv(v1_e, 1'b0, ta);
        send(v2, 3'd7, 1'b1, ta);
        recv(v2_e, 1'b0, ta);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
